det_share_scheduler: RTL and testbench

- Round-robin scheduler that shares one determinant datapath between NREQ requesters.
- The shared datapath is memory read, then two multiplications, then a subtraction. Its controller has a single start input and a done output.
- This block grants the datapath to one requester at a time, issues the start pulses, waits for done, then acknowledges the requester.
- It sits between client blocks and the datapath controller.

---
 rtl/sched_pkg.sv | 15 +
 rtl/rr_picker.sv | 28 ++
 rtl/det_share_scheduler.sv | 96 +++++++++
 tb/tb_det_share_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// sched_pkg: shared state encoding and default sizing for det_share_scheduler.
//   state_t     : 3-bit FSM encoding IDLE=0, LAUNCH=1, WAIT=2, RELEASE=3, ACK=4
//   NREQ_DEF    : default requester count
//   TIMEOUT_DEF : default WAIT abort limit (used only with SCHED_TIMEOUT_EN)
package sched_pkg;
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_WAIT    = 3'd2,
      S_RELEASE = 3'd3,
      S_ACK     = 3'd4
   } state_t;
   localparam int NREQ_DEF    = 4;
   localparam int TIMEOUT_DEF = 64;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner selection.
//   req   : request vector
//   ptr   : index of the last winner (lowest priority this round)
//   valid : at least one request is set
//   idx   : first set bit scanning upward from (ptr+1) mod NREQ with wrap
module rr_picker
   import sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic                    valid,
   output logic [$clog2(NREQ)-1:0] idx
);
   localparam int W = $clog2(NREQ);
   logic [W-1:0] cand;
   // Scan from the farthest position back to the nearest so the nearest hit wins.
   always_comb begin
      valid = |req;
      idx   = '0;
      cand  = '0;
      for (int i = NREQ; i >= 1; i--) begin
         cand = W'((int'(ptr) + i) % NREQ);
         if (req[cand]) idx = cand;
      end
   end
endmodule

// File: rtl/det_share_scheduler.sv
// det_share_scheduler: grants one shared determinant datapath to NREQ clients round-robin.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level request per client, sampled only in IDLE
//   gnt        : one-hot grant held LAUNCH..RELEASE
//   gnt_id     : index of the current or last winner
//   ack        : one-cycle completion pulse to the winner
//   busy       : high whenever not IDLE
//   dp_start   : start pulse in LAUNCH, release pulse in RELEASE
//   dp_done    : datapath finished level, honoured only in WAIT
//   err        : timeout pulse alongside ack (only when SCHED_TIMEOUT_EN is defined)
// Build option SCHED_TIMEOUT_EN adds a WAIT cycle counter that aborts after TIMEOUT cycles.
module det_share_scheduler
   import sched_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_id,
   output logic [NREQ-1:0]         ack,
   output logic                    busy,
   output logic                    dp_start,
   input  logic                    dp_done
`ifdef SCHED_TIMEOUT_EN
   ,
   output logic                    err
`endif
);
   localparam int W = $clog2(NREQ);
   // Out-of-range sizing leaves this empty marker block in the elaborated hierarchy.
   if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_param_out_of_range
   end
   state_t       state, nxt;
   logic [W-1:0] win, ptr, pick_idx;
   logic         pick_v, to_hit;
   logic [NREQ-1:0] win_oh;
   rr_picker #(.NREQ(NREQ)) u_pick (
      .req  (req),
      .ptr  (ptr),
      .valid(pick_v),
      .idx  (pick_idx)
   );
`ifdef SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic          timed_out;
   // The abort fires on the TIMEOUT-th WAIT cycle without dp_done.
   assign to_hit = (state == S_WAIT) && !dp_done && (cnt == CW'(TIMEOUT - 1));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         timed_out <= 1'b0;
      end else if (state == S_LAUNCH) begin
         cnt       <= '0;
         timed_out <= 1'b0;
      end else if (state == S_WAIT) begin
         cnt <= cnt + 1'b1;
         if (to_hit) timed_out <= 1'b1;
      end
   end
   assign err = (state == S_ACK) && timed_out;
`else
   assign to_hit = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         win   <= '0;
         ptr   <= W'(NREQ - 1);
      end else begin
         state <= nxt;
         if (state == S_IDLE && pick_v) win <= pick_idx;
         if (state == S_ACK) ptr <= win;
      end
   end
   always_comb begin
      nxt = S_IDLE;
      case (state)
         S_IDLE:    nxt = pick_v ? S_LAUNCH : S_IDLE;
         S_LAUNCH:  nxt = S_WAIT;
         S_WAIT:    nxt = (dp_done || to_hit) ? S_RELEASE : S_WAIT;
         S_RELEASE: nxt = S_ACK;
         S_ACK:     nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase
   end
   assign win_oh   = NREQ'(1) << win;
   assign gnt      = (state == S_LAUNCH || state == S_WAIT || state == S_RELEASE) ? win_oh : '0;
   assign ack      = (state == S_ACK) ? win_oh : '0;
   assign gnt_id   = win;
   assign busy     = state != S_IDLE;
   assign dp_start = state == S_LAUNCH || state == S_RELEASE;
endmodule

// File: tb/tb_det_share_scheduler.sv
// tb_det_share_scheduler: scoreboard bench with a round-robin reference model and a datapath model.
module tb_det_share_scheduler;
   localparam int N  = 4;
   localparam int TO = 64;
   typedef struct {
      int w;
      int req_cyc;
      bit tmo;
   } exp_t;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic [N-1:0] gnt, ack;
   logic [1:0]   gnt_id;
   logic         busy, dp_start;
   logic         dp_done = 1'b0;
`ifdef SCHED_TIMEOUT_EN
   logic         err;
`endif
   exp_t sb[$];
   int   total = 0, bad = 0, cyc = 0;
   int   ref_ptr = N - 1, dp_delay = 0, done_cyc = -1;
   always #5 clk = ~clk;
   det_share_scheduler #(.NREQ(N), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .ack     (ack),
      .busy    (busy),
      .dp_start(dp_start),
      .dp_done (dp_done)
`ifdef SCHED_TIMEOUT_EN
      ,
      .err     (err)
`endif
   );
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // Datapath model: raises dp_done dp_delay cycles after the start pulse (never if negative),
   // holds it until the release pulse.
   initial begin
      int ph = 0, cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            ph = 0;
            dp_done = 1'b0;
         end else if (ph == 0 && dp_start) begin
            if (dp_delay == 0) begin
               ph = 2;
               dp_done = 1'b1;
               done_cyc = cyc;
            end else begin
               ph = 1;
               cnt = dp_delay;
            end
         end else if (ph != 0 && dp_start) begin
            ph = 0;
            dp_done = 1'b0;
         end else if (ph == 1 && cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               ph = 2;
               dp_done = 1'b1;
               done_cyc = cyc;
            end
         end
      end
   end
   // Monitor: pops the scoreboard as launch, release and ack are observed.
   initial begin
      int   mph = 0, lcyc = 0, rcyc = 0, exp_rel = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            sb.delete();
            mph = 0;
            continue;
         end
         chk("gnt_onehot_or_zero", int'($countones(gnt) <= 1), 1);
`ifdef SCHED_TIMEOUT_EN
         if (ack == '0) chk("err_outside_ack", int'(err), 0);
`endif
         if (dp_start) begin
            chk("sb_nonempty_at_start", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb[0];
               if (mph == 0) begin
                  chk("launch_gnt", int'(gnt), 1 << e.w);
                  chk("launch_gnt_id", int'(gnt_id), e.w);
                  chk("launch_latency", cyc, e.req_cyc + 1);
                  lcyc = cyc;
                  mph = 1;
               end else if (mph == 1) begin
                  exp_rel = e.tmo ? lcyc + 1 + TO : ((done_cyc > lcyc) ? done_cyc : lcyc + 1) + 1;
                  chk("release_latency", cyc, exp_rel);
                  chk("release_gnt", int'(gnt), 1 << e.w);
                  rcyc = cyc;
                  mph = 2;
               end else begin
                  chk("start_phase", mph, 1);
               end
            end
         end
         if (ack != '0) begin
            chk("sb_nonempty_at_ack", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("ack_phase", mph, 2);
               chk("ack_vec", int'(ack), 1 << e.w);
               chk("ack_gnt_zero", int'(gnt), 0);
               chk("ack_gnt_id", int'(gnt_id), e.w);
               chk("ack_latency", cyc, rcyc + 1);
`ifdef SCHED_TIMEOUT_EN
               chk("ack_err", int'(err), int'(e.tmo));
`endif
               mph = 0;
            end
         end
      end
   end
   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait_bound", int'(busy), 0);
   endtask
   // Issue one transaction: val is presented in IDLE, nxt replaces it once granted.
   task automatic txn(input logic [N-1:0] val, input logic [N-1:0] nxt, input int d);
      exp_t e;
      int   w = -1;
      wait_idle();
      for (int j = 1; j <= N; j++)
         if (w < 0 && ((val >> ((ref_ptr + j) % N)) & 4'd1) != 4'd0) w = (ref_ptr + j) % N;
      ref_ptr = w;
      dp_delay = d;
      e.w = w;
      e.req_cyc = cyc;
      e.tmo = d < 0;
      sb.push_back(e);
      req = val;
      @(negedge clk);
      req = nxt;
   endtask
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req = '0;
      #1;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_ack", int'(ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_dp_start", int'(dp_start), 0);
      chk("rst_gnt_id", int'(gnt_id), 0);
`ifdef SCHED_TIMEOUT_EN
      chk("rst_err", int'(err), 0);
`endif
      ref_ptr = N - 1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      do_reset();
      for (int k = 0; k < 5; k++) txn(4'b1111, 4'b1111, int'($urandom_range(0, 6)));
      txn(4'b0100, 4'b0100, 5);
      txn(4'b0010, 4'b0000, 3);
      wait_idle();
      req = '0;
      dp_done = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stale_done_busy", int'(busy), 0);
         chk("stale_done_start", int'(dp_start), 0);
      end
      dp_done = 1'b0;
      txn(4'b0010, 4'b0010, 30);
      repeat (4) @(negedge clk);
      chk("busy_in_wait", int'(busy), 1);
      do_reset();
      txn(4'b1111, 4'b0000, 2);
      txn(4'b0001, 4'b0000, 1);
`ifdef SCHED_TIMEOUT_EN
      txn(4'b0001, 4'b0000, -1);
`endif
      for (int k = 0; k < 25; k++)
         txn(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)));
      wait_idle();
      req = '0;
      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
